// File: rtl/sequencer_loop.sv
// sequencer_loop: cell controller that runs a program out of a local
// instruction RAM. It dispatches resource words to slots, broadcasts activate
// masks, and supports cycle and event waits, jumps and nested hardware loops.
// The RAM is filled from a hop-counted instruction load chain.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | not running; outputs quiet; waits for call
// DECODE | decode iram[pc] this cycle and drive its outputs
// WAIT   | cycle countdown or event wait; pc already points past WAIT
module sequencer_loop #(
    parameter int NUM_SLOTS            = 16,
    parameter int IRAM_DEPTH           = 64,
    parameter int INSTR_DATA_WIDTH     = 32,
    parameter int RESOURCE_INSTR_WIDTH = 27,
    parameter int INSTR_HOPS_WIDTH     = 4,
    parameter int LOOP_DEPTH           = 4,
    parameter int NUM_EVENTS           = 16,
    localparam int AW = $clog2(IRAM_DEPTH)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            call,
    input  logic                            abort,
    input  logic [NUM_EVENTS-1:0]           event_in,
    output logic                            ret,
    output logic                            busy,
    output logic                            err,
    output logic [NUM_SLOTS-1:0]            instr_en,
    output logic [RESOURCE_INSTR_WIDTH-1:0] instr,
    output logic [NUM_SLOTS-1:0]            activate,
    input  logic [INSTR_DATA_WIDTH-1:0]     instr_data_in,
    input  logic [AW-1:0]                   instr_addr_in,
    input  logic [INSTR_HOPS_WIDTH-1:0]     instr_hops_in,
    input  logic                            instr_en_in,
    output logic [INSTR_DATA_WIDTH-1:0]     instr_data_out,
    output logic [AW-1:0]                   instr_addr_out,
    output logic [INSTR_HOPS_WIDTH-1:0]     instr_hops_out,
    output logic                            instr_en_out
);
    localparam int SPW = $clog2(LOOP_DEPTH + 1);
    localparam int LW  = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;

    localparam logic [2:0] OP_HALT       = 3'd0;
    localparam logic [2:0] OP_WAIT       = 3'd1;
    localparam logic [2:0] OP_ACTIVATE   = 3'd2;
    localparam logic [2:0] OP_LOOP_START = 3'd3;
    localparam logic [2:0] OP_LOOP_END   = 3'd4;
    localparam logic [2:0] OP_JUMP       = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [AW-1:0]                 pc_q, pc_d;
    logic [SPW-1:0]                sp_q, sp_d;
    logic [AW-1:0]                 loop_start_q [LOOP_DEPTH];
    logic [AW-1:0]                 loop_start_d [LOOP_DEPTH];
    logic [15:0]                   loop_rem_q [LOOP_DEPTH];
    logic [15:0]                   loop_rem_d [LOOP_DEPTH];
    logic [26:0]                   wait_cnt_q, wait_cnt_d;
    logic                          wait_evt_q, wait_evt_d;
    logic [3:0]                    wait_idx_q, wait_idx_d;
    logic                          err_q, err_d;
    logic [INSTR_DATA_WIDTH-1:0]   iram_q [IRAM_DEPTH];
    logic [INSTR_DATA_WIDTH-1:0]   iram_d [IRAM_DEPTH];
    logic [INSTR_DATA_WIDTH-1:0]   chain_data_q, chain_data_d;
    logic [AW-1:0]                 chain_addr_q, chain_addr_d;
    logic [INSTR_HOPS_WIDTH-1:0]   chain_hops_q, chain_hops_d;
    logic                          chain_en_q, chain_en_d;

    logic [31:0]    word;
    logic           w_type;
    logic [2:0]     w_op;
    logic [3:0]     w_slot;
    logic [23:0]    w_payload;
    logic [3:0]     w_idx;
    logic [AW-1:0]  pc_inc;
    logic [LW-1:0]  push_idx;
    logic [LW-1:0]  top_idx;
    logic [15:0]    evt_pad;
    logic [15:0]    loop_cnt;

    assign word      = 32'(iram_q[pc_q]);
    assign w_type    = word[31];
    assign w_op      = word[30:28];
    assign w_slot    = word[27:24];
    assign w_payload = word[23:0];
    assign w_idx     = word[3:0];
    assign pc_inc    = pc_q + AW'(1);
    assign push_idx  = LW'(sp_q);
    assign top_idx   = LW'(sp_q - SPW'(1));
    assign evt_pad   = 16'(event_in);
    assign loop_cnt  = (word[15:0] == 16'd0) ? 16'd1 : word[15:0];

    assign busy           = (state_q != S_IDLE);
    assign err            = err_q;
    assign instr_data_out = chain_data_q;
    assign instr_addr_out = chain_addr_q;
    assign instr_hops_out = chain_hops_q;
    assign instr_en_out   = chain_en_q;

    // Load chain: write locally when hops hit zero, else forward one hop on.
    always_comb begin
        iram_d       = iram_q;
        chain_data_d = '0;
        chain_addr_d = '0;
        chain_hops_d = '0;
        chain_en_d   = 1'b0;
        if (instr_en_in) begin
            if (instr_hops_in == '0) begin
                iram_d[instr_addr_in] = instr_data_in;
            end else begin
                chain_data_d = instr_data_in;
                chain_addr_d = instr_addr_in;
                chain_hops_d = instr_hops_in - INSTR_HOPS_WIDTH'(1);
                chain_en_d   = 1'b1;
            end
        end
    end

    // Sequencer next-state, loop stack, wait counter and decode outputs.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        sp_d         = sp_q;
        loop_start_d = loop_start_q;
        loop_rem_d   = loop_rem_q;
        wait_cnt_d   = wait_cnt_q;
        wait_evt_d   = wait_evt_q;
        wait_idx_d   = wait_idx_q;
        err_d        = err_q;
        ret          = 1'b0;
        instr_en     = '0;
        instr        = '0;
        activate     = '0;
        case (state_q)
            S_IDLE: begin
                if (!abort && call) begin
                    state_d = S_DECODE;
                    pc_d    = '0;
                    sp_d    = '0;
                    err_d   = 1'b0;
                end
            end
            S_DECODE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    pc_d    = '0;
                    sp_d    = '0;
                end else if (w_type) begin
                    instr = RESOURCE_INSTR_WIDTH'({w_op, w_payload});
                    if (32'(w_slot) < NUM_SLOTS) begin
                        instr_en = NUM_SLOTS'(1) << w_slot;
                    end else begin
                        err_d = 1'b1;
                    end
                    pc_d = pc_inc;
                end else begin
                    case (w_op)
                        OP_HALT: begin
                            ret     = 1'b1;
                            pc_d    = '0;
                            sp_d    = '0;
                            state_d = S_IDLE;
                        end
                        OP_WAIT: begin
                            pc_d = pc_inc;
                            if (word[27]) begin
                                if (32'(w_idx) >= NUM_EVENTS) begin
                                    err_d = 1'b1;
                                end else if (!evt_pad[w_idx]) begin
                                    state_d    = S_WAIT;
                                    wait_evt_d = 1'b1;
                                    wait_idx_d = w_idx;
                                end
                            end else if (word[26:0] != 27'd0) begin
                                state_d    = S_WAIT;
                                wait_evt_d = 1'b0;
                                wait_cnt_d = word[26:0];
                            end
                        end
                        OP_ACTIVATE: begin
                            activate = NUM_SLOTS'(word[27:12]);
                            pc_d     = pc_inc;
                        end
                        OP_LOOP_START: begin
                            if (sp_q == SPW'(LOOP_DEPTH)) begin
                                err_d   = 1'b1;
                                state_d = S_IDLE;
                                pc_d    = '0;
                                sp_d    = '0;
                            end else begin
                                loop_start_d[push_idx] = pc_q;
                                loop_rem_d[push_idx]   = loop_cnt;
                                sp_d = sp_q + SPW'(1);
                                pc_d = pc_inc;
                            end
                        end
                        OP_LOOP_END: begin
                            if (sp_q == '0) begin
                                err_d   = 1'b1;
                                state_d = S_IDLE;
                                pc_d    = '0;
                            end else if (loop_rem_q[top_idx] > 16'd1) begin
                                loop_rem_d[top_idx] = loop_rem_q[top_idx] - 16'd1;
                                pc_d = loop_start_q[top_idx] + AW'(1);
                            end else begin
                                sp_d = sp_q - SPW'(1);
                                pc_d = pc_inc;
                            end
                        end
                        OP_JUMP: begin
                            pc_d = word[AW-1:0];
                        end
                        default: begin
                            pc_d = pc_inc;
                        end
                    endcase
                end
            end
            S_WAIT: begin
                if (abort) begin
                    state_d    = S_IDLE;
                    pc_d       = '0;
                    sp_d       = '0;
                    wait_cnt_d = '0;
                end else if (wait_evt_q) begin
                    if (evt_pad[wait_idx_q]) begin
                        state_d = S_DECODE;
                    end
                end else if (wait_cnt_q <= 27'd1) begin
                    wait_cnt_d = '0;
                    state_d    = S_DECODE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 27'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // All state registers, including the instruction RAM, clear on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            sp_q         <= '0;
            wait_cnt_q   <= '0;
            wait_evt_q   <= 1'b0;
            wait_idx_q   <= '0;
            err_q        <= 1'b0;
            chain_data_q <= '0;
            chain_addr_q <= '0;
            chain_hops_q <= '0;
            chain_en_q   <= 1'b0;
            for (int i = 0; i < LOOP_DEPTH; i++) begin
                loop_start_q[i] <= '0;
                loop_rem_q[i]   <= '0;
            end
            for (int i = 0; i < IRAM_DEPTH; i++) begin
                iram_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            sp_q         <= sp_d;
            wait_cnt_q   <= wait_cnt_d;
            wait_evt_q   <= wait_evt_d;
            wait_idx_q   <= wait_idx_d;
            err_q        <= err_d;
            chain_data_q <= chain_data_d;
            chain_addr_q <= chain_addr_d;
            chain_hops_q <= chain_hops_d;
            chain_en_q   <= chain_en_d;
            loop_start_q <= loop_start_d;
            loop_rem_q   <= loop_rem_d;
            iram_q       <= iram_d;
        end
    end

endmodule

// File: tb/tb_sequencer_loop.sv
// Bench for sequencer_loop: directed programs, expected outputs queued at
// call time and matched by a negedge monitor against what the DUT presents.
module tb_sequencer_loop;
    localparam int NS  = 16;
    localparam int AW  = 6;
    localparam int RIW = 27;
    localparam int HW  = 4;
    localparam int NE  = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           call = 1'b0;
    logic           abort = 1'b0;
    logic [NE-1:0]  event_in = '0;
    logic           ret, busy, err;
    logic [NS-1:0]  instr_en, activate;
    logic [RIW-1:0] instr;
    logic [31:0]    instr_data_in = '0;
    logic [31:0]    instr_data_out;
    logic [AW-1:0]  instr_addr_in = '0;
    logic [AW-1:0]  instr_addr_out;
    logic [HW-1:0]  instr_hops_in = '0;
    logic [HW-1:0]  instr_hops_out;
    logic           instr_en_in = 1'b0;
    logic           instr_en_out;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int             cyc;
        logic [NS-1:0]  en;
        logic [RIW-1:0] ins;
        logic [NS-1:0]  act;
        logic           r;
    } ev_t;
    ev_t exp_q[$];

    sequencer_loop dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .call           (call),
        .abort          (abort),
        .event_in       (event_in),
        .ret            (ret),
        .busy           (busy),
        .err            (err),
        .instr_en       (instr_en),
        .instr          (instr),
        .activate       (activate),
        .instr_data_in  (instr_data_in),
        .instr_addr_in  (instr_addr_in),
        .instr_hops_in  (instr_hops_in),
        .instr_en_in    (instr_en_in),
        .instr_data_out (instr_data_out),
        .instr_addr_out (instr_addr_out),
        .instr_hops_out (instr_hops_out),
        .instr_en_out   (instr_en_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: any visible decode output must match the queue head.
    always @(negedge clk) begin
        ev_t e;
        if (instr_en != '0 || activate != '0 || ret) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_output cyc=%0d en=%h instr=%h act=%h ret=%b",
                         cyc, instr_en, instr, activate, ret);
            end else begin
                e = exp_q.pop_front();
                if (cyc != e.cyc || instr_en !== e.en || instr !== e.ins ||
                    activate !== e.act || ret !== e.r) begin
                    n_errors++;
                    $display("FAIL scoreboard got cyc=%0d en=%h instr=%h act=%h ret=%b, expected cyc=%0d en=%h instr=%h act=%h ret=%b",
                             cyc, instr_en, instr, activate, ret, e.cyc, e.en, e.ins, e.act, e.r);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    function automatic void expect_ev(input int c, input logic [NS-1:0] en,
                                      input logic [RIW-1:0] ins, input logic [NS-1:0] act,
                                      input logic r);
        ev_t e;
        e.cyc = c;
        e.en  = en;
        e.ins = ins;
        e.act = act;
        e.r   = r;
        exp_q.push_back(e);
    endfunction

    task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
        tick();
        instr_en_in   = 1'b1;
        instr_hops_in = '0;
        instr_addr_in = a;
        instr_data_in = d;
        tick();
        instr_en_in   = 1'b0;
    endtask

    task automatic begin_call(output int c0);
        tick();
        c0   = cyc;
        call = 1'b1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick();
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s: got %0d outputs still pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (4) tick();
    endtask

    initial begin
        int c0;

        // Reset state
        repeat (2) tick();
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        check("rst_instr_en", 32'(instr_en), 0);
        check("rst_instr", 32'(instr), 0);
        check("rst_activate", 32'(activate), 0);
        check("rst_ret", 32'(ret), 0);
        check("rst_chain_en", 32'(instr_en_out), 0);
        rst_n = 1'b1;

        // Two-hop word is forwarded with hops-1 and does not land locally
        tick();
        instr_en_in   = 1'b1;
        instr_hops_in = 4'd2;
        instr_addr_in = 6'd7;
        instr_data_in = 32'h8500_0055;
        tick();
        instr_en_in   = 1'b0;
        @(negedge clk);
        check("fwd_en", 32'(instr_en_out), 1);
        check("fwd_hops", 32'(instr_hops_out), 1);
        check("fwd_addr", 32'(instr_addr_out), 7);
        check("fwd_data", instr_data_out, 32'h8500_0055);
        tick();
        @(negedge clk);
        check("fwd_idle_en", 32'(instr_en_out), 0);
        check("fwd_idle_data", instr_data_out, 0);

        load(6'd0, 32'h5000_0007);
        @(negedge clk);
        check("local_write_chain_en", 32'(instr_en_out), 0);
        begin_call(c0);
        expect_ev(c0 + 2, '0, '0, '0, 1'b1);
        tick();
        call = 1'b0;
        drain("jump_to_unwritten");

        // Local write at address 5 is executed
        load(6'd5, 32'hB200_0055);
        load(6'd6, 32'h0000_0000);
        load(6'd0, 32'h5000_0005);
        begin_call(c0);
        expect_ev(c0 + 2, 16'h0004, 27'h300_0055, '0, 1'b0);
        expect_ev(c0 + 3, '0, '0, '0, 1'b1);
        tick();
        call = 1'b0;
        drain("load_addr5");

        // Resource / WAIT 3 / ACTIVATE / HALT
        load(6'd0, 32'hA30A_BCDE);
        load(6'd1, 32'h1000_0003);
        load(6'd2, 32'h2000_5000);
        load(6'd3, 32'h0000_0000);
        begin_call(c0);
        expect_ev(c0 + 1, 16'h0008, 27'h20A_BCDE, '0, 1'b0);
        expect_ev(c0 + 6, '0, '0, 16'h0005, 1'b0);
        expect_ev(c0 + 7, '0, '0, '0, 1'b1);
        tick();
        call = 1'b0;
        wait_cyc(c0 + 4);
        @(negedge clk);
        check("wait3_busy", 32'(busy), 1);
        wait_cyc(c0 + 8);
        @(negedge clk);
        check("halt_busy_low", 32'(busy), 0);
        drain("basic_program");

        // Loop of 3, call held high while busy must be ignored
        load(6'd0, 32'h3000_0003);
        load(6'd1, 32'h8100_0111);
        load(6'd2, 32'h4000_0000);
        load(6'd3, 32'h0000_0000);
        begin_call(c0);
        expect_ev(c0 + 2, 16'h0002, 27'h000_0111, '0, 1'b0);
        expect_ev(c0 + 4, 16'h0002, 27'h000_0111, '0, 1'b0);
        expect_ev(c0 + 6, 16'h0002, 27'h000_0111, '0, 1'b0);
        expect_ev(c0 + 8, '0, '0, '0, 1'b1);
        repeat (4) tick();
        call = 1'b0;
        drain("loop3");

        // Loop stack overflow: err, no ret, next call clears err
        for (int i = 0; i < 5; i++) load(AW'(i), 32'h3000_0002);
        load(6'd5, 32'h0000_0000);
        begin_call(c0);
        tick();
        call = 1'b0;
        wait_cyc(c0 + 5);
        @(negedge clk);
        check("ovf_busy_before", 32'(busy), 1);
        check("ovf_err_before", 32'(err), 0);
        tick();
        @(negedge clk);
        check("ovf_busy_after", 32'(busy), 0);
        check("ovf_err_after", 32'(err), 1);
        repeat (4) tick();
        begin_call(c0);
        tick();
        call = 1'b0;
        @(negedge clk);
        check("ovf_err_cleared", 32'(err), 0);
        wait_cyc(c0 + 6);
        @(negedge clk);
        check("ovf_err_again", 32'(err), 1);
        drain("overflow");

        // Event wait already satisfied
        load(6'd0, 32'h1800_0002);
        load(6'd1, 32'h9400_0044);
        load(6'd2, 32'h0000_0000);
        event_in[2] = 1'b1;
        begin_call(c0);
        expect_ev(c0 + 2, 16'h0010, 27'h100_0044, '0, 1'b0);
        expect_ev(c0 + 3, '0, '0, '0, 1'b1);
        tick();
        call = 1'b0;
        drain("event_ready");
        event_in[2] = 1'b0;

        // Event raised at cycle 10
        begin_call(c0);
        expect_ev(c0 + 11, 16'h0010, 27'h100_0044, '0, 1'b0);
        expect_ev(c0 + 12, '0, '0, '0, 1'b1);
        tick();
        call = 1'b0;
        event_in[3] = 1'b1;
        wait_cyc(c0 + 9);
        @(negedge clk);
        check("event_still_waiting", 32'(busy), 1);
        wait_cyc(c0 + 10);
        event_in[3] = 1'b0;
        event_in[2] = 1'b1;
        tick();
        event_in[2] = 1'b0;
        drain("event_at_10");

        // Abort during event wait
        begin_call(c0);
        tick();
        call = 1'b0;
        wait_cyc(c0 + 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("abort_wait_busy", 32'(busy), 0);
        check("abort_wait_err", 32'(err), 0);
        event_in[2] = 1'b1;
        repeat (3) tick();
        event_in[2] = 1'b0;
        drain("abort_wait");

        // Reset in the middle of a long cycle wait
        load(6'd0, 32'h1000_0014);
        load(6'd1, 32'h8600_0066);
        load(6'd2, 32'h0000_0000);
        begin_call(c0);
        tick();
        call = 1'b0;
        wait_cyc(c0 + 5);
        @(negedge clk);
        check("pre_reset_busy", 32'(busy), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("midwait_rst_busy", 32'(busy), 0);
        check("midwait_rst_err", 32'(err), 0);
        check("midwait_rst_en", 32'(instr_en), 0);
        check("midwait_rst_chain", 32'(instr_en_out), 0);
        begin_call(c0);
        expect_ev(c0 + 1, '0, '0, '0, 1'b1);
        tick();
        call = 1'b0;
        drain("iram_cleared");

        // Abort in DECODE suppresses the strobe; then a clean run with WAIT 0
        load(6'd0, 32'h8700_0077);
        load(6'd1, 32'h1000_0000);
        load(6'd2, 32'h0000_0000);
        begin_call(c0);
        tick();
        call  = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        check("abort_decode_en", 32'(instr_en), 0);
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("abort_decode_busy", 32'(busy), 0);
        repeat (3) tick();
        begin_call(c0);
        expect_ev(c0 + 1, 16'h0080, 27'h000_0077, '0, 1'b0);
        expect_ev(c0 + 3, '0, '0, '0, 1'b1);
        tick();
        call = 1'b0;
        drain("wait0");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
